memory_cycle: RTL and testbench
===============================

Name: memory_cycle

Overview:
- MEM stage of the 5-stage RV32 pipeline. It sits directly downstream of the execute stage and consumes that stage's M-side pipeline register outputs.
- Drives a wait-state data-memory bus with a req/ack handshake. It stalls the pipeline until the access completes and times out hung accesses.
- Owns the MEM/WB pipeline register that feeds writeback.

Parameters:
- TIMEOUT, 16, max cycles spent in WAIT without dmem_ack before the access is declared faulted.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low (rst==0 resets)
- RegWriteM  in  1  register write enable from execute stage
- MemWriteM  in  1  store enable
- ResultSrcM  in  1  1 = load (writeback takes memory data)
- RD_M  in  5  destination register
- PCPlus4M  in  32  PC+4 of the instruction
- WriteDataM  in  32  store data (already forwarded)
- ALU_ResultM  in  32  effective address / ALU result
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  byte address (= ALU_ResultM)
- dmem_wdata  out  32  = WriteDataM
- dmem_rdata  in  32  read data, valid in the cycle dmem_ack=1
- dmem_ack  in  1  access complete
- StallM  out  1  to hazard unit; freezes F/D/E and the execute-stage register
- MemFault  out  1  sticky fault flag
- RegWriteW, ResultSrcW  out  1 each  MEM/WB control
- RD_W  out  5  MEM/WB destination
- PCPlus4W, ALU_ResultW, ReadDataW  out  32 each  MEM/WB data

Behaviour:
- access = MemWriteM | ResultSrcM. misaligned = access & (ALU_ResultM[1:0] != 0). Word accesses only.
- States: IDLE, WAIT, FAULT. Wait counter cnt is CNT_W bits wide.
- IDLE:
  - dmem_req = access & ~misaligned.
  - dmem_ack in the same cycle gives a zero-wait completion: StallM=0, W captures the instruction.
  - Otherwise, if a request is issued: go to WAIT, cnt<=1, StallM=1.
  - misaligned: no request, go to FAULT, MemFault<=1, W loads a bubble.
- WAIT:
  - dmem_req held high. dmem_we, dmem_addr and dmem_wdata stay stable because the upstream register is frozen.
  - ack: go to IDLE, StallM=0, W captures the instruction with ReadDataW=dmem_rdata.
  - No ack and cnt==TIMEOUT: go to FAULT, MemFault<=1, StallM=0, W loads a bubble. The instruction is dropped.
  - Otherwise cnt<=cnt+1, StallM=1.
- FAULT:
  - Terminal until reset. dmem_req=0, StallM=0. W loads only bubbles. MemFault=1.
- StallM is combinational: (IDLE & req & ~ack) | (WAIT & ~(ack | cnt==TIMEOUT)).
- MEM/WB register:
  - Updates every clk.
  - While StallM=1 or on a fault it loads a bubble: RegWriteW=0, ResultSrcW=0, other fields 0.
  - Otherwise it captures the M inputs. ReadDataW = dmem_rdata on a load completion, 0 otherwise.
- Non-memory instructions (access=0) pass through in 1 cycle with dmem_req=0.
- dmem_ack while no request is outstanding is ignored.
- Stores complete with RegWriteW as presented, normally 0.
- Reset (async, any state, including mid-WAIT):
  - state=IDLE, cnt=0, MemFault=0, all W outputs 0.
  - dmem_req drops immediately because the upstream registers also reset to 0, giving access=0.
  - A late ack after reset is ignored.
- Latency: 1 cycle plus wait states. A completed instruction's W fields appear on the clk edge where ack=1 is sampled.

Decomposition:
- Shared pipeline package: FSM state encoding (IDLE=2'd0, WAIT=2'd1, FAULT=2'd2), XLEN=32, REG_ADDR_W=5.
- One natural sub-module: mem_wb_reg, the bubble-capable MEM/WB pipeline register. The FSM and bus logic stay in memory_cycle.

Test Plan:
- ALU op: ALU_ResultM=0x1234, RegWriteM=1, RD_M=5 -> dmem_req=0, StallM=0; next edge RD_W=5, ALU_ResultW=0x1234, RegWriteW=1.
- Load at 0x100, ack on cycle 3 with rdata=0xDEADBEEF -> StallM=1 for 2 cycles and W bubbles (RegWriteW=0). On the ack edge ReadDataW=0xDEADBEEF, ResultSrcW=1.
- Store 0xCAFEF00D to 0x20 with ack in the same cycle -> dmem_req=1, dmem_we=1, dmem_wdata=0xCAFEF00D, StallM never asserted.
- Load at 0x40, ack never asserted, TIMEOUT=16 -> StallM high 16 cycles, then MemFault=1, StallM=0. All later instructions bubble until reset.
- Load at 0x102 (misaligned) -> dmem_req=0, MemFault=1 next edge, W bubble.
- rst=0 asserted mid-WAIT, then ack arrives -> state IDLE, MemFault=0, W outputs 0, ack ignored.

Source files
------------

// File: rtl/memory_cycle_pkg.sv
// Shared pipeline definitions: data widths, MEM-stage FSM encoding, MEM/WB record.
package memory_cycle_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                  reg_write;
    logic                  result_src;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       read_data;
  } mem_wb_t;

endpackage

// File: rtl/memory_cycle_if.sv
// Wait-state data-memory bus with req/ack handshake.
interface memory_cycle_if;
  import memory_cycle_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/memory_cycle_mem_wb_reg.sv
// MEM/WB pipeline register; loads the M-side record or an all-zero bubble every clock.
module mem_wb_reg
  import memory_cycle_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    capture,
  input  mem_wb_t m_in,
  output mem_wb_t w_out
);

  mem_wb_t w_d, w_q;

  // Capture the instruction or insert a bubble.
  always_comb begin
    w_d = '0;
    if (capture) w_d = m_in;
  end

  // Register with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_q <= '0;
    else        w_q <= w_d;
  end

  assign w_out = w_q;

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: drives the data-memory handshake, stalls until completion,
// times out hung accesses into a sticky fault, and owns MEM/WB.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemWriteM,
  input  logic                  ResultSrcM,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [XLEN-1:0]       WriteDataM,
  input  logic [XLEN-1:0]       ALU_ResultM,
  memory_cycle_if.master        dmem,
  output logic                  StallM,
  output logic                  MemFault,
  output logic                  RegWriteW,
  output logic                  ResultSrcW,
  output logic [REG_ADDR_W-1:0] RD_W,
  output logic [XLEN-1:0]       PCPlus4W,
  output logic [XLEN-1:0]       ALU_ResultW,
  output logic [XLEN-1:0]       ReadDataW
);

  mem_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             fault_d, fault_q;

  logic    access, misaligned, timeout_hit;
  logic    req, stall, capture, load_done;
  mem_wb_t m_rec, w_rec;

  assign access      = MemWriteM | ResultSrcM;
  assign misaligned  = access & (ALU_ResultM[1:0] != 2'b00);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));

  // Next state, wait counter, and handshake/stall/capture decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    req     = 1'b0;
    stall   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req   = access & ~misaligned;
        cnt_d = '0;
        if (misaligned) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else if (req && !dmem.dmem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
          stall   = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (dmem.dmem_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          capture = 1'b1;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          stall = 1'b1;
        end
      end
      ST_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and sticky fault registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // capture is only ever set for a completed access or a non-memory op,
  // so a load that captures necessarily has dmem_ack high this cycle.
  assign load_done = capture & ResultSrcM & dmem.dmem_ack;

  // Assemble the M-side record for MEM/WB.
  always_comb begin
    m_rec            = '0;
    m_rec.reg_write  = RegWriteM;
    m_rec.result_src = ResultSrcM;
    m_rec.rd         = RD_M;
    m_rec.pc_plus4   = PCPlus4M;
    m_rec.alu_result = ALU_ResultM;
    m_rec.read_data  = load_done ? dmem.dmem_rdata : '0;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk     (clk),
    .rst_n   (rst),
    .capture (capture),
    .m_in    (m_rec),
    .w_out   (w_rec)
  );

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = MemWriteM;
  assign dmem.dmem_addr  = ALU_ResultM;
  assign dmem.dmem_wdata = WriteDataM;

  assign StallM      = stall;
  assign MemFault    = fault_q;
  assign RegWriteW   = w_rec.reg_write;
  assign ResultSrcW  = w_rec.result_src;
  assign RD_W        = w_rec.rd;
  assign PCPlus4W    = w_rec.pc_plus4;
  assign ALU_ResultW = w_rec.alu_result;
  assign ReadDataW   = w_rec.read_data;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for the MEM stage: single-cycle vector table plus multi-cycle sequences.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        StallM, MemFault, RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  int total = 0;
  int bad   = 0;

  memory_cycle_if bus ();

  memory_cycle #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM),
    .dmem        (bus.master),
    .StallM      (StallM),
    .MemFault    (MemFault),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .PCPlus4W    (PCPlus4W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] pc4, wd, alu;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we, e_stall;
    logic        e_rw, e_rs;
    logic [4:0]  e_rd;
    logic [31:0] e_rdw;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [31:0] wd, input logic [31:0] alu,
                       input logic ack, input logic [31:0] rdata);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc4; WriteDataM = wd; ALU_ResultM = alu;
    bus.dmem_ack = ack; bus.dmem_rdata = rdata;
  endtask

  function automatic vec_t mk(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                              input logic [31:0] pc4, input logic [31:0] wd, input logic [31:0] alu,
                              input logic ack, input logic [31:0] rdata,
                              input logic e_req, input logic e_we, input logic e_stall,
                              input logic e_rw, input logic e_rs, input logic [4:0] e_rd,
                              input logic [31:0] e_rdw);
    vec_t v;
    v.rw = rw; v.mw = mw; v.rs = rs; v.rd = rd; v.pc4 = pc4; v.wd = wd; v.alu = alu;
    v.ack = ack; v.rdata = rdata; v.e_req = e_req; v.e_we = e_we; v.e_stall = e_stall;
    v.e_rw = e_rw; v.e_rs = e_rs; v.e_rd = e_rd; v.e_rdw = e_rdw;
    return v;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #1 chk("rst_memfault", {31'b0, MemFault}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //            rw mw rs rd     pc4          wd            alu          ack rdata        req we st  rw rs rd     rdataW
    vecs[0] = mk(1, 0, 0, 5'd5,  32'h104, 32'h0,        32'h1234,     0, 32'h0,        0, 0, 0,  1, 0, 5'd5,  32'h0);
    vecs[1] = mk(0, 1, 0, 5'd0,  32'h108, 32'hCAFEF00D, 32'h20,       1, 32'h0,        1, 1, 0,  0, 0, 5'd0,  32'h0);
    vecs[2] = mk(1, 0, 1, 5'd7,  32'h10C, 32'h0,        32'h200,      1, 32'h11223344, 1, 0, 0,  1, 1, 5'd7,  32'h11223344);
    vecs[3] = mk(1, 0, 0, 5'd31, 32'h110, 32'h0,        32'h55,       1, 32'hFFFFFFFF, 0, 0, 0,  1, 0, 5'd31, 32'h0);
    vecs[4] = mk(1, 0, 0, 5'd2,  32'h114, 32'h0,        32'h3,        0, 32'h0,        0, 0, 0,  1, 0, 5'd2,  32'h0);
    vecs[5] = mk(1, 1, 0, 5'd4,  32'h118, 32'h0BADF00D, 32'hFFFFFFFC, 1, 32'h9,        1, 1, 0,  1, 0, 5'd4,  32'h0);

    rst = 1'b0;
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_regwritew", {31'b0, RegWriteW}, 32'd0);
    chk("reset_readdataw", ReadDataW, 32'd0);
    chk("reset_memfault", {31'b0, MemFault}, 32'd0);
    chk("reset_stall", {31'b0, StallM}, 32'd0);
    chk("reset_req", {31'b0, bus.dmem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].rd, vecs[i].pc4, vecs[i].wd,
            vecs[i].alu, vecs[i].ack, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, bus.dmem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_stall", i), {31'b0, StallM}, {31'b0, vecs[i].e_stall});
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_we", i), {31'b0, bus.dmem_we}, {31'b0, vecs[i].e_we});
        chk($sformatf("v%0d_addr", i), bus.dmem_addr, vecs[i].alu);
        chk($sformatf("v%0d_wdata", i), bus.dmem_wdata, vecs[i].wd);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rw_w", i), {31'b0, RegWriteW}, {31'b0, vecs[i].e_rw});
      chk($sformatf("v%0d_rs_w", i), {31'b0, ResultSrcW}, {31'b0, vecs[i].e_rs});
      chk($sformatf("v%0d_rd_w", i), {27'b0, RD_W}, {27'b0, vecs[i].e_rd});
      chk($sformatf("v%0d_alu_w", i), ALU_ResultW, vecs[i].alu);
      chk($sformatf("v%0d_pc4_w", i), PCPlus4W, vecs[i].pc4);
      chk($sformatf("v%0d_rdata_w", i), ReadDataW, vecs[i].e_rdw);
      chk($sformatf("v%0d_fault", i), {31'b0, MemFault}, 32'd0);
    end

    // Load at 0x100 with ack on the third cycle.
    @(negedge clk);
    drive(1, 0, 1, 5'd10, 32'h200, 32'h0, 32'h100, 0, 32'h0);
    #1;
    chk("ld3_c1_stall", {31'b0, StallM}, 32'd1);
    chk("ld3_c1_req", {31'b0, bus.dmem_req}, 32'd1);
    chk("ld3_c1_we", {31'b0, bus.dmem_we}, 32'd0);
    @(posedge clk); #1;
    chk("ld3_c1_bubble", {31'b0, RegWriteW}, 32'd0);
    @(negedge clk); #1;
    chk("ld3_c2_stall", {31'b0, StallM}, 32'd1);
    chk("ld3_c2_req", {31'b0, bus.dmem_req}, 32'd1);
    @(posedge clk); #1;
    chk("ld3_c2_bubble", {31'b0, RegWriteW}, 32'd0);
    @(negedge clk);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld3_c3_stall", {31'b0, StallM}, 32'd0);
    @(posedge clk); #1;
    chk("ld3_rdata_w", ReadDataW, 32'hDEADBEEF);
    chk("ld3_rs_w", {31'b0, ResultSrcW}, 32'd1);
    chk("ld3_rw_w", {31'b0, RegWriteW}, 32'd1);
    chk("ld3_rd_w", {27'b0, RD_W}, 32'd10);

    // Load at 0x40 that never completes: 16 stall cycles, then sticky fault.
    @(negedge clk);
    drive(1, 0, 1, 5'd11, 32'h300, 32'h0, 32'h40, 0, 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!StallM) break;
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("to_stall_cycles", n, 32'd16);
    chk("to_req_last", {31'b0, bus.dmem_req}, 32'd1);
    @(posedge clk); #1;
    chk("to_memfault", {31'b0, MemFault}, 32'd1);
    chk("to_bubble", {31'b0, RegWriteW}, 32'd0);
    @(negedge clk);
    drive(1, 0, 0, 5'd9, 32'h304, 32'h0, 32'h77, 0, 32'h0);
    #1;
    chk("flt_alu_stall", {31'b0, StallM}, 32'd0);
    @(posedge clk); #1;
    chk("flt_alu_bubble_rw", {31'b0, RegWriteW}, 32'd0);
    chk("flt_alu_bubble_rd", {27'b0, RD_W}, 32'd0);
    @(negedge clk);
    drive(1, 0, 1, 5'd9, 32'h308, 32'h0, 32'h80, 1, 32'h1234);
    #1;
    chk("flt_ld_req", {31'b0, bus.dmem_req}, 32'd0);
    @(posedge clk); #1;
    chk("flt_ld_bubble", ReadDataW, 32'd0);
    chk("flt_sticky", {31'b0, MemFault}, 32'd1);
    pulse_reset();

    // Misaligned load at 0x102.
    @(negedge clk);
    drive(1, 0, 1, 5'd3, 32'h400, 32'h0, 32'h102, 0, 32'h0);
    #1;
    chk("mis_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("mis_stall", {31'b0, StallM}, 32'd0);
    @(posedge clk); #1;
    chk("mis_memfault", {31'b0, MemFault}, 32'd1);
    chk("mis_rw_w", {31'b0, RegWriteW}, 32'd0);
    chk("mis_rs_w", {31'b0, ResultSrcW}, 32'd0);
    chk("mis_alu_w", ALU_ResultW, 32'd0);
    pulse_reset();

    // Reset asserted mid-WAIT, then a late ack.
    @(negedge clk);
    drive(1, 0, 1, 5'd12, 32'h500, 32'h0, 32'h80, 0, 32'h0);
    @(posedge clk);
    @(negedge clk); #1;
    chk("rw_wait_stall", {31'b0, StallM}, 32'd1);
    rst = 1'b0;
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    chk("rw_rst_rw", {31'b0, RegWriteW}, 32'd0);
    chk("rw_rst_fault", {31'b0, MemFault}, 32'd0);
    chk("rw_rst_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rw_rst_stall", {31'b0, StallM}, 32'd0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h55;
    @(posedge clk); #1;
    chk("rw_late_ack_rdata", ReadDataW, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rw_post_rdata", ReadDataW, 32'd0);
    chk("rw_post_rs", {31'b0, ResultSrcW}, 32'd0);
    @(negedge clk);
    drive(1, 0, 1, 5'd13, 32'h600, 32'h0, 32'h84, 1, 32'h77);
    #1;
    chk("rw_idle_req", {31'b0, bus.dmem_req}, 32'd1);
    chk("rw_idle_stall", {31'b0, StallM}, 32'd0);
    @(posedge clk); #1;
    chk("rw_idle_rdata", ReadDataW, 32'h77);
    chk("rw_idle_rs", {31'b0, ResultSrcW}, 32'd1);
    chk("rw_idle_rd", {27'b0, RD_W}, 32'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
